// File: rtl/adc_lvds_serializer.sv
// -----------------------------------------------------------------------------
// adc_lvds_serializer
//
// Transmit-side model of an octal serial ADC link. Parallel per-channel sample
// words are accepted through a valid/ready handshake and sent MSB first, one
// bit per clk, on CHANNELS single-data-rate lanes. A frame clock (fco) is high
// for the first WIDTH/2 bits of each frame. After enable rises, SYNC_FRAMES
// copies of SYNC_WORD are sent on every lane so a receiver can align on the
// fco rising edge, then live data follows.
//
// Ports:
//   clk        bit clock, one serial bit per rising edge
//   rst_n      asynchronous active-low reset
//   enable     start/stop; only its value at a frame boundary matters
//   din        sample words, channel c at din[c*WIDTH +: WIDTH]
//   din_valid  din holds a new frame
//   din_ready  combinational; high on the boundary cycle of a RUN load
//   sdata      serial lanes, bit c is lane c
//   fco        frame clock
//   active     high while the transmitter is in RUN
//   underrun   one-cycle pulse after a RUN load that found no valid data
//
// Optional build macro ADC_SER_TEST_PATTERN_EN: a RUN load without valid data
// sends a per-lane ramp ((ramp + c) mod 2^WIDTH) instead of repeating the last
// accepted frame. With the macro undefined no ramp register exists.
// -----------------------------------------------------------------------------
module adc_lvds_serializer #(
  parameter int               WIDTH       = 14,
  parameter int               CHANNELS    = 8,
  parameter int               SYNC_FRAMES = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 14'h2A55
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [CHANNELS-1:0]       sdata,
  output logic                      fco,
  output logic                      active,
  output logic                      underrun
);

  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(SYNC_FRAMES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(WIDTH / 2);
  localparam logic [FW-1:0] FRM_LAST = FW'(SYNC_FRAMES);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [CW-1:0]                    bit_cnt;
  logic [FW-1:0]                    frm_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   shreg;
  logic [CHANNELS-1:0][WIDTH-1:0]   hold;
  logic [CHANNELS-1:0][WIDTH-1:0]   run_word;
  logic                             boundary;
  logic                             load_sync;
  logic                             load_run;
  logic                             go_idle;
`ifdef ADC_SER_TEST_PATTERN_EN
  logic [WIDTH-1:0]                 ramp;
`endif

  // bit_cnt parks at LAST_BIT in IDLE, so every IDLE cycle is a boundary and
  // a rising enable is acted on at the very next edge.
  assign boundary = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    load_sync = 1'b0;
    load_run  = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SYNC;
          load_sync = 1'b1;
        end
      end
      SYNC: begin
        if (boundary) begin
          if (!enable) begin
            state_nxt = IDLE;
            go_idle   = 1'b1;
          end else if (frm_cnt < FRM_LAST) begin
            load_sync = 1'b1;
          end else begin
            state_nxt = RUN;
            load_run  = 1'b1;
          end
        end
      end
      RUN: begin
        if (boundary) begin
          if (!enable) begin
            state_nxt = IDLE;
            go_idle   = 1'b1;
          end else begin
            load_run = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        go_idle   = 1'b1;
      end
    endcase
  end

  // A RUN load is exactly the moment the block can take a new frame.
  assign din_ready = load_run;

  // Word loaded at a RUN boundary: fresh data if offered, otherwise the fill
  // pattern (last accepted frame, or the ramp when the test pattern is built).
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      run_word[c] = hold[c];
      if (din_valid) begin
        run_word[c] = din[c*WIDTH +: WIDTH];
      end
`ifdef ADC_SER_TEST_PATTERN_EN
      else begin
        run_word[c] = ramp + WIDTH'(c);
      end
`endif
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sdata[c] = shreg[c][WIDTH-1];
    end
  end

  // ---- frame control and shift stage: registers feed sdata/fco directly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= LAST_BIT;
      frm_cnt  <= '0;
      shreg    <= '0;
      hold     <= '0;
      fco      <= 1'b0;
      active   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      active   <= (state_nxt == RUN);
      underrun <= load_run & ~din_valid;

      // fco tracks the value bit_cnt is about to take, so it rises together
      // with the MSB that the load places on sdata.
      if (load_sync || load_run) begin
        bit_cnt <= '0;
        fco     <= 1'b1;
      end else if (go_idle || state == IDLE) begin
        bit_cnt <= LAST_BIT;
        fco     <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        fco     <= ((bit_cnt + CW'(1)) < HALF_BIT);
      end

      if (load_sync) begin
        frm_cnt <= (state == IDLE) ? FW'(1) : frm_cnt + FW'(1);
      end else if (go_idle) begin
        frm_cnt <= '0;
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (load_sync) begin
          shreg[c] <= SYNC_WORD;
        end else if (load_run) begin
          shreg[c] <= run_word[c];
        end else if (go_idle || state == IDLE) begin
          shreg[c] <= '0;
        end else begin
          shreg[c] <= {shreg[c][WIDTH-2:0], 1'b0};
        end
      end

      if (load_run && din_valid) begin
        hold <= din;
      end
    end
  end

`ifdef ADC_SER_TEST_PATTERN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else if (load_run && !din_valid) begin
      ramp <= ramp + WIDTH'(1);
    end
  end
`endif

endmodule
